nios2_cpu_debug_cmd_sync: RTL and testbench
===========================================

Name: nios2_cpu_debug_cmd_sync

Overview:
System-clock-side receiver for the CPU debug JTAG link, and the parametrised successor of the fixed 2-bit-IR, 38-bit sysclk action decoder. It synchronises the tck-domain update strobes and captures the IR and shift-register contents into a command FIFO. It then hands commands to the debug core with a valid/ready handshake, generating per-instruction take_action / take_no_action pulses. It sits between the virtual-JTAG tck logic and the OCI break/ocimem/trace controllers.

Parameters:
IR_W, 2, instruction register width; 2**IR_W action channels
DATA_W, 38, shift-register (jdo) width
FIFO_DEPTH, 4, command FIFO entries; power of two, >=2
SYNC_STAGES, 2, synchroniser flops per strobe; >=2
ACTION_BIT, 35, bit of captured data selecting action (1) vs no-action (0); < DATA_W

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ir_in  in  IR_W  tck-domain IR; stable while strobes high
sr  in  DATA_W  tck-domain shift register; stable while vs_udr high
vs_udr  in  1  update-DR strobe, asynchronous to clk
vs_uir  in  1  update-IR strobe, asynchronous to clk
cmd_valid  out  1  FIFO head valid
cmd_ready  in  1  consumer accepts head
cmd_update_dr  out  1  head kind: 1 = DR update, 0 = IR update
cmd_ir  out  IR_W  head IR value
cmd_data  out  DATA_W  head data (jdo); zero for IR updates
take_action  out  2**IR_W  one-hot, one-cycle pulse on DR pop with data[ACTION_BIT]=1
take_no_action  out  2**IR_W  one-hot, one-cycle pulse on DR pop with data[ACTION_BIT]=0
fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries
overflow  out  1  sticky: command dropped
clear_overflow  in  1  clears overflow

Behaviour:
- Reset: all outputs 0; FIFO empty; synchroniser flops 0; both edge detectors disarmed.
- Synchroniser: each strobe passes through a SYNC_STAGES flop chain. Each detector arms when its synced value is seen 0. A rising edge counts only when armed, so a strobe held high across reset release is ignored.
- Capture (same cycle as detected edge):
  - udr edge: push {1, ir_in, sr}.
  - uir edge: push {0, ir_in, 0}.
  - ir_in/sr are sampled directly; tck logic holds them stable while the strobe is high.
- Latency: if vs_udr is first sampled high at edge k, cmd_valid is high after edge k+SYNC_STAGES (empty FIFO).
- Simultaneous udr and uir edges: push the udr command; drop uir and set overflow.
- FIFO: first-word fall-through, so cmd_* show the head while cmd_valid=1. Pop when cmd_valid && cmd_ready. cmd_ready with empty FIFO is ignored.
- Full: a push while full with no pop in the same cycle is dropped and sets overflow; contents are unchanged. Push and pop in the same cycle when full: both occur, level unchanged, no overflow.
- Pointers wrap modulo FIFO_DEPTH; fifo_level is exact (0..FIFO_DEPTH).
- Action pulses, registered, one cycle after the popping edge:
  - On a DR pop, take_action[cmd_ir] or take_no_action[cmd_ir] pulses for exactly one cycle, per data[ACTION_BIT].
  - IR pops produce no pulses.
  - Consecutive pops produce back-to-back pulses.
- overflow: sticky. clear_overflow clears it. If clear and set occur in the same cycle, set wins.
- Reset mid-operation: FIFO flushed, pending pulses cancelled, detectors disarmed.

Optional Feature:
NIOS2_DBG_CMD_TIMESTAMP_EN
- Defined:
  - Adds a free-running 16-bit cycle counter (reset 0, wraps 0xFFFF->0).
  - Each FIFO entry also stores the counter value at capture, presented on extra output cmd_stamp[15:0] with the head.
- Undefined: no counter, no cmd_stamp port, FIFO width DATA_W+IR_W+1.

Test Plan:
- Reset, then vs_udr held 8 cycles with ir_in=2'b01, sr=38'h08_0000_0000 (bit35=1), cmd_ready=1 → cmd_valid first high after edge k+2. Next cycle: take_action=4'b0010 for one cycle; take_no_action=0; fifo_level back to 0.
- vs_uir pulse with ir_in=2'b11 → one entry with cmd_update_dr=0, cmd_ir=3, cmd_data=0; no action pulses on pop.
- cmd_ready=0; five udr strobes, sr[7:0]=1..5 → fifo_level=4, overflow=1. Then cmd_ready=1 → pops data 1,2,3,4 in order. clear_overflow → overflow=0.
- vs_udr and vs_uir rise in the same clk cycle → exactly one DR entry; overflow=1.
- vs_udr held high through reset deassertion → no command. Strobe drops and rises again → exactly one command.
- NIOS2_DBG_CMD_TIMESTAMP_EN defined: strobes at cycles 10 and 30 after reset → cmd_stamp differs by 20. Counter wrap from 0xFFFF produces stamp 0x0000.

Source files
------------

// File: rtl/nios2_cpu_debug_cmd_sync.sv
// System-clock receiver for the CPU debug JTAG link: synchronises tck update strobes,
// queues IR/DR commands in a FWFT FIFO. Optional: NIOS2_DBG_CMD_TIMESTAMP_EN adds cmd_stamp.
module nios2_cpu_debug_cmd_sync #(
    parameter int IR_W        = 2,
    parameter int DATA_W      = 38,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACTION_BIT  = 35
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IR_W-1:0]               ir_in,
    input  logic [DATA_W-1:0]             sr,
    input  logic                          vs_udr,
    input  logic                          vs_uir,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic                          cmd_update_dr,
    output logic [IR_W-1:0]               cmd_ir,
    output logic [DATA_W-1:0]             cmd_data,
`ifdef NIOS2_DBG_CMD_TIMESTAMP_EN
    output logic [15:0]                   cmd_stamp,
`endif
    output logic [(2**IR_W)-1:0]          take_action,
    output logic [(2**IR_W)-1:0]          take_no_action,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clear_overflow
);

    localparam int NCH = 2**IR_W;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int FW  = $clog2(SYNC_STAGES + 1);

    // ------------------------------------------------------------------
    // Strobe synchronisers and armed edge detectors (index 0 = udr, 1 = uir)
    // ------------------------------------------------------------------
    logic [1:0]             w_strobe_raw;
    logic [SYNC_STAGES-1:0] r_sync [2];
    logic [1:0]             r_armed;
    logic [1:0]             w_synced;
    logic [1:0]             w_edge;
    logic [FW-1:0]          r_fill;
    logic                   w_primed;

    assign w_strobe_raw = {vs_uir, vs_udr};
    // The chain holds reset zeros until it has been refilled with real samples;
    // arming only on genuine lows keeps a strobe held across reset from firing.
    assign w_primed     = (r_fill == FW'(SYNC_STAGES));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fill <= '0;
        end else if (!w_primed) begin
            r_fill <= r_fill + FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed <= '0;
            for (int i = 0; i < 2; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_strobe_raw[i]};
                if (w_edge[i]) begin
                    r_armed[i] <= 1'b0;
                end else if (w_primed && !w_synced[i]) begin
                    r_armed[i] <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            assign w_synced[gi] = r_sync[gi][SYNC_STAGES-1];
            assign w_edge[gi]   = r_armed[gi] & w_synced[gi];
        end
    endgenerate

    logic w_udr_edge;
    logic w_uir_edge;
    assign w_udr_edge = w_edge[0];
    assign w_uir_edge = w_edge[1];

    // ------------------------------------------------------------------
    // Command FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic              r_mem_kind [FIFO_DEPTH];
    logic [IR_W-1:0]   r_mem_ir   [FIFO_DEPTH];
    logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;

    logic              w_valid;
    logic              w_full;
    logic              w_pop;
    logic              w_push_req;
    logic              w_push;
    logic              w_drop;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_head_kind;
    logic [IR_W-1:0]   w_head_ir;
    logic [DATA_W-1:0] w_head_data;

    assign w_valid    = (r_level != '0);
    assign w_full     = (r_level == LW'(FIFO_DEPTH));
    assign w_pop      = w_valid & cmd_ready;
    assign w_push_req = w_udr_edge | w_uir_edge;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = (w_udr_edge & w_uir_edge) | (w_push_req & w_full & ~w_pop);
    assign w_wr_data  = w_udr_edge ? sr : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_kind[r_wr_ptr] <= w_udr_edge;
            r_mem_ir[r_wr_ptr]   <= ir_in;
            r_mem_data[r_wr_ptr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign w_head_kind = r_mem_kind[r_rd_ptr];
    assign w_head_ir   = r_mem_ir[r_rd_ptr];
    assign w_head_data = r_mem_data[r_rd_ptr];

    // Head fields are masked so an empty FIFO presents all zeros.
    assign cmd_valid     = w_valid;
    assign cmd_update_dr = w_valid & w_head_kind;
    assign cmd_ir        = w_valid ? w_head_ir   : '0;
    assign cmd_data      = w_valid ? w_head_data : '0;
    assign fifo_level    = r_level;

`ifdef NIOS2_DBG_CMD_TIMESTAMP_EN
    logic [15:0] r_stamp_cnt;
    logic [15:0] r_mem_stamp [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stamp_cnt <= '0;
        end else begin
            r_stamp_cnt <= r_stamp_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_stamp[r_wr_ptr] <= r_stamp_cnt;
        end
    end

    assign cmd_stamp = w_valid ? r_mem_stamp[r_rd_ptr] : '0;
`endif

    // ------------------------------------------------------------------
    // Per-instruction action pulses, one cycle after the popping edge
    // ------------------------------------------------------------------
    logic [NCH-1:0] w_ir_hit;
    logic [NCH-1:0] r_take_action;
    logic [NCH-1:0] r_take_no_action;
    logic           w_dr_pop;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_decode
            assign w_ir_hit[gi] = (w_head_ir == IR_W'(gi));
        end
    endgenerate

    assign w_dr_pop = w_pop & w_head_kind;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_take_action    <= '0;
            r_take_no_action <= '0;
        end else begin
            r_take_action    <= (w_dr_pop &&  w_head_data[ACTION_BIT]) ? w_ir_hit : '0;
            r_take_no_action <= (w_dr_pop && !w_head_data[ACTION_BIT]) ? w_ir_hit : '0;
        end
    end

    assign take_action    = r_take_action;
    assign take_no_action = r_take_no_action;

    // ------------------------------------------------------------------
    // Sticky overflow; a new drop outranks a clear in the same cycle
    // ------------------------------------------------------------------
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;

endmodule

// File: tb/tb_nios2_cpu_debug_cmd_sync.sv
// Bench for nios2_cpu_debug_cmd_sync: vector table plus hand-written corner sequences,
// with a scoreboard queue checked whenever the DUT pops a command.
`timescale 1ns/1ps
module tb_nios2_cpu_debug_cmd_sync;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        vs_udr;
    logic        vs_uir;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_update_dr;
    logic [1:0]  cmd_ir;
    logic [37:0] cmd_data;
    logic [3:0]  take_action;
    logic [3:0]  take_no_action;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        clear_overflow;
`ifdef NIOS2_DBG_CMD_TIMESTAMP_EN
    logic [15:0] cmd_stamp;
`endif

    always #5 clk = ~clk;

    nios2_cpu_debug_cmd_sync dut (
        .clk            (clk),
        .reset          (reset),
        .ir_in          (ir_in),
        .sr             (sr),
        .vs_udr         (vs_udr),
        .vs_uir         (vs_uir),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_update_dr  (cmd_update_dr),
        .cmd_ir         (cmd_ir),
        .cmd_data       (cmd_data),
`ifdef NIOS2_DBG_CMD_TIMESTAMP_EN
        .cmd_stamp      (cmd_stamp),
`endif
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    typedef struct {
        logic        kind;
        logic [1:0]  ir;
        logic [37:0] data;
        logic [3:0]  act;
        logic [3:0]  noact;
        logic        chk_stamp;
        logic [15:0] stamp;
    } exp_t;

    typedef struct {
        logic        is_dr;
        logic [1:0]  ir;
        logic [37:0] sr;
        logic [37:0] exp_data;
        logic [3:0]  act;
        logic [3:0]  noact;
    } vec_t;

    exp_t        sb[$];
    logic [15:0] stamp_log[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          pop_cnt  = 0;
    logic [3:0]  exp_act  = '0;
    logic [3:0]  exp_noact = '0;
    logic [15:0] tb_cyc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Free-running cycle reference for timestamp expectations
    always @(posedge clk) begin
        if (reset) tb_cyc <= 16'd0;
        else       tb_cyc <= tb_cyc + 16'd1;
    end

    // Scoreboard monitor: checks pulses every cycle and the head on every pop
    always @(negedge clk) begin
        logic [3:0] nxt_act;
        logic [3:0] nxt_noact;
        exp_t       e;
        if (reset) begin
            sb.delete();
            exp_act   = '0;
            exp_noact = '0;
        end else begin
            chk("take_action", take_action, exp_act);
            chk("take_no_action", take_no_action, exp_noact);
            nxt_act   = '0;
            nxt_noact = '0;
            if (cmd_valid && cmd_ready) begin
                pop_cnt++;
`ifdef NIOS2_DBG_CMD_TIMESTAMP_EN
                stamp_log.push_back(cmd_stamp);
`endif
                $display("pop %0d: dr=%0d ir=%0d data=%h", pop_cnt, cmd_update_dr, cmd_ir, cmd_data);
                if (sb.size() == 0) begin
                    chk("unexpected_pop", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("cmd_update_dr", cmd_update_dr, e.kind);
                    chk("cmd_ir", cmd_ir, e.ir);
                    chk("cmd_data", cmd_data, e.data);
`ifdef NIOS2_DBG_CMD_TIMESTAMP_EN
                    if (e.chk_stamp) chk("cmd_stamp", cmd_stamp, e.stamp);
`endif
                    nxt_act   = e.act;
                    nxt_noact = e.noact;
                end
            end
            exp_act   = nxt_act;
            exp_noact = nxt_noact;
        end
    end

    task automatic push_exp(input logic kind, input logic [1:0] ir, input logic [37:0] data,
                            input logic [3:0] act, input logic [3:0] noact);
        exp_t e;
        e = '{kind: kind, ir: ir, data: data, act: act, noact: noact, chk_stamp: 1'b0, stamp: 16'd0};
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 60 && sb.size() != 0; i++) step();
        chk(nm, sb.size(), 0);
    endtask

    task automatic apply_vec(input vec_t v);
        step();
        ir_in = v.ir;
        sr    = v.sr;
        if (v.is_dr) vs_udr = 1'b1;
        else         vs_uir = 1'b1;
        push_exp(v.is_dr, v.ir, v.exp_data, v.act, v.noact);
        @(negedge clk);
        @(negedge clk); chk("latency_k", cmd_valid, 0);
        @(negedge clk); chk("latency_k1", cmd_valid, 0);
        @(negedge clk); chk("latency_k2", cmd_valid, 1);
        repeat (5) step();
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk("level_after_vec", fifo_level, 0);
        chk("sb_after_vec", sb.size(), 0);
    endtask

    task automatic strobe_udr(input logic [1:0] ir, input logic [37:0] data);
        step();
        ir_in  = ir;
        sr     = data;
        vs_udr = 1'b1;
        repeat (3) step();
        vs_udr = 1'b0;
        repeat (4) step();
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (5) step();
    endtask

    vec_t vecs[6];
    int   p0;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{is_dr: 1'b1, ir: 2'd1, sr: 38'h08_0000_0000, exp_data: 38'h08_0000_0000, act: 4'b0010, noact: 4'b0000};
        vecs[1] = '{is_dr: 1'b0, ir: 2'd3, sr: 38'h3F_FFFF_FFFF, exp_data: 38'h0,            act: 4'b0000, noact: 4'b0000};
        vecs[2] = '{is_dr: 1'b1, ir: 2'd0, sr: 38'h00_1234_5678, exp_data: 38'h00_1234_5678, act: 4'b0000, noact: 4'b0001};
        vecs[3] = '{is_dr: 1'b1, ir: 2'd3, sr: 38'h3F_FFFF_FFFF, exp_data: 38'h3F_FFFF_FFFF, act: 4'b1000, noact: 4'b0000};
        vecs[4] = '{is_dr: 1'b1, ir: 2'd2, sr: 38'h37_FFFF_FFFF, exp_data: 38'h37_FFFF_FFFF, act: 4'b0000, noact: 4'b0100};
        vecs[5] = '{is_dr: 1'b0, ir: 2'd0, sr: 38'h00_0000_0000, exp_data: 38'h0,            act: 4'b0000, noact: 4'b0000};

        reset = 1'b1; ir_in = '0; sr = '0; vs_udr = 1'b0; vs_uir = 1'b0;
        cmd_ready = 1'b1; clear_overflow = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_take_action", take_action, 0);
        chk("rst_take_no_action", take_no_action, 0);
        chk("rst_cmd_data", cmd_data, 0);
        step();
        reset = 1'b0;
        repeat (5) step();

        for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

        // Overflow: five strobes into a four-entry FIFO with the consumer stalled
        cmd_ready = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            if (n <= 4) push_exp(1'b1, 2'd2, 38'(n), 4'b0000, 4'b0100);
            strobe_udr(2'd2, 38'(n));
        end
        @(negedge clk);
        chk("full_level", fifo_level, 4);
        chk("full_overflow", overflow, 1);
        step();
        cmd_ready = 1'b1;
        wait_drain("drain_after_full");
        repeat (3) step();
        @(negedge clk);
        chk("drained_level", fifo_level, 0);
        chk("overflow_sticky", overflow, 1);
        step(); clear_overflow = 1'b1;
        step(); clear_overflow = 1'b0;
        @(negedge clk);
        chk("overflow_cleared", overflow, 0);

        // Simultaneous udr/uir edges: the DR command wins, IR is dropped
        p0 = pop_cnt;
        step();
        ir_in = 2'd1; sr = 38'h1; vs_udr = 1'b1; vs_uir = 1'b1;
        push_exp(1'b1, 2'd1, 38'h1, 4'b0000, 4'b0010);
        repeat (3) step();
        vs_udr = 1'b0; vs_uir = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk("simul_pops", pop_cnt - p0, 1);
        chk("simul_overflow", overflow, 1);
        step(); clear_overflow = 1'b1;
        step(); clear_overflow = 1'b0;

        // Strobe held high across reset release must not produce a command
        step();
        reset = 1'b1; vs_udr = 1'b1; ir_in = 2'd0; sr = 38'h5;
        repeat (3) step();
        reset = 1'b0;
        p0 = pop_cnt;
        repeat (8) step();
        @(negedge clk);
        chk("held_no_cmd", pop_cnt - p0, 0);
        chk("held_level", fifo_level, 0);
        step();
        vs_udr = 1'b0;
        repeat (4) step();
        push_exp(1'b1, 2'd0, 38'h5, 4'b0000, 4'b0001);
        vs_udr = 1'b1;
        repeat (3) step();
        vs_udr = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk("held_then_one_cmd", pop_cnt - p0, 1);

        // Reset mid-operation flushes queued commands
        cmd_ready = 1'b0;
        strobe_udr(2'd3, 38'h08_0000_0000);
        strobe_udr(2'd3, 38'h08_0000_0000);
        @(negedge clk);
        chk("pre_reset_level", fifo_level, 2);
        step(); reset = 1'b1;
        step(); step(); reset = 1'b0;
        @(negedge clk);
        chk("post_reset_level", fifo_level, 0);
        chk("post_reset_valid", cmd_valid, 0);
        p0 = pop_cnt;
        step(); cmd_ready = 1'b1;
        repeat (6) step();
        @(negedge clk);
        chk("post_reset_no_pop", pop_cnt - p0, 0);

`ifdef NIOS2_DBG_CMD_TIMESTAMP_EN
        // Capture lands two cycles after the first high sample
        begin
            exp_t e;
            do_reset();
            cmd_ready = 1'b0;
            stamp_log.delete();
            for (int i = 0; i < 100 && tb_cyc != 16'd8; i++) step();
            ir_in = 2'd1; sr = 38'h0; vs_udr = 1'b1;
            e = '{kind: 1'b1, ir: 2'd1, data: 38'h0, act: 4'b0000, noact: 4'b0010, chk_stamp: 1'b1, stamp: 16'd10};
            sb.push_back(e);
            repeat (3) step();
            vs_udr = 1'b0;
            for (int i = 0; i < 100 && tb_cyc != 16'd28; i++) step();
            vs_udr = 1'b1;
            e.stamp = 16'd30;
            sb.push_back(e);
            repeat (3) step();
            vs_udr = 1'b0;
            repeat (4) step();
            cmd_ready = 1'b1;
            wait_drain("stamp_drain");
            chk("stamp_count", stamp_log.size(), 2);
            if (stamp_log.size() == 2) chk("stamp_delta", stamp_log[1] - stamp_log[0], 20);
            for (int i = 0; i < 70000 && tb_cyc != 16'hFFFE; i++) step();
            vs_udr = 1'b1;
            e.stamp = 16'h0000;
            sb.push_back(e);
            repeat (3) step();
            vs_udr = 1'b0;
            wait_drain("stamp_wrap_drain");
        end
`endif

        repeat (4) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
